ram_copier: RTL and testbench

RAM_COPIER -- requirements
Module: ram_copier

---
 rtl/ram_copier_if.sv | 28 ++
 rtl/ram_copier.sv | 88 ++++++++
 tb/tb_ram_copier.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ram_copier_if.sv
// Bundle of the copier's control handshake and its single memory port.
// master = copier side, slave = the environment (controller plus memory).
interface ram_copier_if;
   localparam int unsigned AW = 9;
   localparam int unsigned DW = 16;
   localparam int unsigned LW = 10;

   logic          start;
   logic [AW-1:0] src;
   logic [AW-1:0] dst;
   logic [LW-1:0] len;
   logic          busy;
   logic          done;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_in;
   logic          mem_load;
   logic [DW-1:0] mem_out;

   modport master (
      input  start, src, dst, len, mem_out,
      output busy, done, mem_address, mem_in, mem_load
   );

   modport slave (
      output start, src, dst, len, mem_out,
      input  busy, done, mem_address, mem_in, mem_load
   );
endinterface

// File: rtl/ram_copier.sv
// Copies up to 512 words inside a 512x16 memory, one read and one write per word,
// ascending addresses with wrap-around and no overlap detection.
module ram_copier (
   input logic          clk,
   input logic          reset,
   ram_copier_if.master cp_io
);
   localparam int unsigned AW = 9;
   localparam int unsigned DW = 16;
   localparam int unsigned LW = 10;
   localparam logic [LW-1:0] MAX_LEN = LW'(512);

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] src_q, src_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [LW-1:0] rem_q, rem_d;
   logic [DW-1:0] data_q, data_d;

   logic [LW-1:0] eff_len;
   logic [LW-1:0] rem_dec;

   // Lengths beyond the memory size saturate to a full-memory copy.
   assign eff_len = (cp_io.len > MAX_LEN) ? MAX_LEN : cp_io.len;
   assign rem_dec = rem_q - LW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
      end
   end

   // Memory port signals decode from the current state, so a write in flight
   // when reset is sampled still lands on that edge.
   always_comb begin
      state_d           = state_q;
      src_d             = src_q;
      dst_d             = dst_q;
      rem_d             = rem_q;
      data_d            = data_q;
      cp_io.busy        = 1'b0;
      cp_io.done        = 1'b0;
      cp_io.mem_address = '0;
      cp_io.mem_in      = data_q;
      cp_io.mem_load    = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            cp_io.done = (state_q == ST_DONE);
            if (cp_io.start) begin
               src_d   = cp_io.src;
               dst_d   = cp_io.dst;
               rem_d   = eff_len;
               state_d = (eff_len != '0) ? ST_READ : ST_DONE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            cp_io.busy        = 1'b1;
            cp_io.mem_address = src_q;
            data_d            = cp_io.mem_out;
            state_d           = ST_WRITE;
         end
         ST_WRITE: begin
            cp_io.busy        = 1'b1;
            cp_io.mem_address = dst_q;
            cp_io.mem_load    = 1'b1;
            src_d             = src_q + AW'(1);
            dst_d             = dst_q + AW'(1);
            rem_d             = rem_dec;
            state_d           = (rem_dec != '0) ? ST_READ : ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end
endmodule

// File: tb/tb_ram_copier.sv
// Directed bench for ram_copier: a table of copies with hand-computed timing and
// data, plus sequences for reset abort, ignored start while busy, and DONE restart.
module tb_ram_copier;
   logic clk;
   logic reset;
   ram_copier_if bus ();

   logic [15:0] mem  [512];
   logic [15:0] gold [512];

   int n_vec;
   int n_err;

   ram_copier dut (
      .clk   (clk),
      .reset (reset),
      .cp_io (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.mem_out = mem[bus.mem_address];

   always @(posedge clk) begin
      if (bus.mem_load) mem[bus.mem_address] <= bus.mem_in;
   end

   typedef struct {
      logic [8:0]  src;
      logic [8:0]  dst;
      logic [9:0]  len;
      int          exp_done;
      int          exp_wr;
      logic [8:0]  chk_addr;
      logic [15:0] chk_val;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // mem[10..13] = A000..A003, everything else follows the same ramp.
   task automatic preload();
      for (int i = 0; i < 512; i++) begin
         mem[i]  = 16'(32'hA000 + i - 10);
         gold[i] = 16'(32'hA000 + i - 10);
      end
      mem[20]  = 16'h1111;  gold[20] = 16'h1111;
      mem[21]  = 16'h2222;  gold[21] = 16'h2222;
   endtask

   task automatic gold_copy(input logic [8:0] s, input logic [8:0] d, input logic [9:0] l);
      int eff;
      eff = (l > 10'd512) ? 512 : int'(l);
      for (int i = 0; i < eff; i++)
         gold[(int'(d) + i) % 512] = gold[(int'(s) + i) % 512];
   endtask

   task automatic gold_cmp(input string name);
      int bad;
      bad = 0;
      for (int i = 0; i < 512; i++)
         if (mem[i] !== gold[i]) bad++;
      chk(name, 32'(bad), 32'd0);
   endtask

   // Starts a copy at a negedge; cycle k is sampled at the negedge k cycles after acceptance.
   task automatic run_copy(input logic [8:0] s, input logic [8:0] d, input logic [9:0] l,
                           output int done_at, output int wr, output int busy_bad);
      int cyc;
      @(negedge clk);
      bus.start = 1'b1; bus.src = s; bus.dst = d; bus.len = l;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 1; wr = 0; done_at = -1; busy_bad = 0;
      while (done_at < 0 && cyc <= 1100) begin
         if (bus.mem_load) wr++;
         if (bus.done) begin
            done_at = cyc;
            if (bus.busy || bus.mem_load) busy_bad++;
         end else begin
            if (!bus.busy) busy_bad++;
            @(negedge clk);
            cyc++;
         end
      end
   endtask

   initial begin
      int done_at, wr, busy_bad, cyc;
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      bus.start = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0;

      vecs[0] = '{9'd10,  9'd100, 10'd4,    9,    4,   9'd103, 16'hA003};
      vecs[1] = '{9'd510, 9'd0,   10'd4,    9,    4,   9'd1,   16'hA1F5};
      vecs[2] = '{9'd0,   9'd0,   10'd0,    1,    0,   9'd0,   16'h9FF6};
      vecs[3] = '{9'd20,  9'd21,  10'd2,    5,    2,   9'd22,  16'h1111};
      vecs[4] = '{9'd300, 9'd50,  10'd1,    3,    1,   9'd50,  16'hA122};
      vecs[5] = '{9'd0,   9'd256, 10'd600,  1025, 512, 9'd300, 16'hA022};
      vecs[6] = '{9'd100, 9'd200, 10'd1023, 1025, 512, 9'd205, 16'hA05F};

      preload();
      @(posedge clk);
      @(negedge clk);
      chk("rst_busy",  32'(bus.busy), 32'd0);
      chk("rst_done",  32'(bus.done), 32'd0);
      chk("rst_load",  32'(bus.mem_load), 32'd0);
      chk("rst_addr",  32'(bus.mem_address), 32'd0);
      chk("rst_min",   32'(bus.mem_in), 32'd0);
      reset = 1'b0;

      for (int v = 0; v < 7; v++) begin
         preload();
         gold_copy(vecs[v].src, vecs[v].dst, vecs[v].len);
         run_copy(vecs[v].src, vecs[v].dst, vecs[v].len, done_at, wr, busy_bad);
         chk($sformatf("v%0d_done_cycle", v), 32'(done_at), 32'(vecs[v].exp_done));
         chk($sformatf("v%0d_writes", v), 32'(wr), 32'(vecs[v].exp_wr));
         chk($sformatf("v%0d_busy", v), 32'(busy_bad), 32'd0);
         @(negedge clk);
         chk($sformatf("v%0d_word", v), 32'(mem[vecs[v].chk_addr]), 32'(vecs[v].chk_val));
         gold_cmp($sformatf("v%0d_image", v));
      end

      // Reset during the 3rd WRITE of a len=8 copy: that write lands, nothing after.
      preload();
      @(negedge clk);
      bus.start = 1'b1; bus.src = 9'd10; bus.dst = 9'd100; bus.len = 10'd8;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      wr = 0;
      for (int c = 1; c <= 6; c++) begin
         if (bus.mem_load) wr++;
         if (c == 6) reset = 1'b1;
         @(negedge clk);
      end
      reset = 1'b0;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_load", 32'(bus.mem_load), 32'd0);
      busy_bad = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus.mem_load) wr++;
         if (bus.done) busy_bad++;
         @(negedge clk);
      end
      chk("abort_writes", 32'(wr), 32'd3);
      chk("abort_nodone", 32'(busy_bad), 32'd0);
      chk("abort_w102", 32'(mem[102]), 32'h0000A002);
      chk("abort_w103", 32'(mem[103]), 32'h0000A05D);

      // start pulsed while busy is ignored; start held in DONE restarts immediately.
      preload();
      @(negedge clk);
      bus.start = 1'b1; bus.src = 9'd10; bus.dst = 9'd100; bus.len = 10'd4;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 1; done_at = -1;
      while (done_at < 0 && cyc <= 50) begin
         if (bus.done) done_at = cyc;
         else begin
            if (cyc == 3) begin
               bus.start = 1'b1; bus.src = 9'd200; bus.dst = 9'd300; bus.len = 10'd1;
            end else begin
               bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
         end
      end
      chk("busy_start_done_cycle", 32'(done_at), 32'd9);
      chk("busy_start_w103", 32'(mem[103]), 32'h0000A003);
      chk("busy_start_w300", 32'(mem[300]), 32'h0000A122);
      bus.start = 1'b1; bus.src = 9'd300; bus.dst = 9'd400; bus.len = 10'd1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("restart_busy", 32'(bus.busy), 32'd1);
      chk("restart_addr", 32'(bus.mem_address), 32'd300);
      @(negedge clk);
      chk("restart_load", 32'(bus.mem_load), 32'd1);
      @(negedge clk);
      chk("restart_done", 32'(bus.done), 32'd1);
      chk("restart_w400", 32'(mem[400]), 32'h0000A122);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
